// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// alu_exec_ctrl : four-state execute sequencer around an external ALU
//                 (operand read, ALU drive, result capture, write-back/PSR).
// Revision      : 1.0
// ============================================================================
module alu_exec_ctrl #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [3:0]       in_rdest,
  input  logic [3:0]       in_rsrc,
  input  logic [7:0]       in_imm,
  input  logic             in_imm_en,
  input  logic             in_imm_signed,
  output logic [WIDTH-1:0] alu_rdest,
  output logic [WIDTH-1:0] alu_rsrc,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic [4:0]       alu_flags,
  output logic [4:0]       psr,
  output logic             wb_valid,
  output logic [3:0]       wb_addr,
  output logic [WIDTH-1:0] wb_data,
  input  logic [3:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  localparam logic [4:0] c_OP_ADD  = 5'd0;
  localparam logic [4:0] c_OP_SUB  = 5'd1;
  localparam logic [4:0] c_OP_CMP  = 5'd2;
  localparam logic [4:0] c_OP_LAST = 5'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t           state_q;
  logic [4:0]       op_q;
  logic [3:0]       rdest_q;
  logic [3:0]       rsrc_q;
  logic [7:0]       imm_q;
  logic             imm_en_q;
  logic             imm_signed_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [4:0]       aluop_q;
  logic [WIDTH-1:0] res_q;
  logic [4:0]       flags_q;
  logic [4:0]       psr_q;
  logic             wb_valid_q;
  logic [3:0]       wb_addr_q;
  logic             in_ready_q;
  logic [WIDTH-1:0] regs_q [NREGS];

  logic [WIDTH-1:0] imm_ext_d;
  logic [WIDTH-1:0] opb_d;
  logic             writes_d;
  logic [4:0]       psr_d;

  assign imm_ext_d = {{(WIDTH-8){imm_q[7] & imm_signed_q}}, imm_q};
  assign opb_d     = imm_en_q ? imm_ext_d : regs_q[rsrc_q];
  assign writes_d  = (op_q <= c_OP_LAST) && (op_q != c_OP_CMP);

  // Z is recomputed here: ADD/SUB report a zero result, CMP reports equality.
  always_comb begin
    psr_d = psr_q;
    if (op_q == c_OP_ADD || op_q == c_OP_SUB) begin
      psr_d = {flags_q[4], (res_q == '0), flags_q[2:0]};
    end else if (op_q == c_OP_CMP) begin
      psr_d = {flags_q[4], (opa_q == opb_q), flags_q[2:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      rdest_q      <= '0;
      rsrc_q       <= '0;
      imm_q        <= '0;
      imm_en_q     <= 1'b0;
      imm_signed_q <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      aluop_q      <= '0;
      res_q        <= '0;
      flags_q      <= '0;
      psr_q        <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      in_ready_q   <= 1'b1;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            op_q         <= in_op;
            rdest_q      <= in_rdest;
            rsrc_q       <= in_rsrc;
            imm_q        <= in_imm;
            imm_en_q     <= in_imm_en;
            imm_signed_q <= in_imm_signed;
            in_ready_q   <= 1'b0;
            state_q      <= S_READ;
          end
        end
        S_READ: begin
          opa_q   <= regs_q[rdest_q];
          opb_q   <= opb_d;
          aluop_q <= op_q;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_q      <= alu_out;
          flags_q    <= alu_flags;
          wb_addr_q  <= rdest_q;
          wb_valid_q <= writes_d;
          state_q    <= S_WB;
        end
        S_WB: begin
          if (wb_valid_q) begin
            regs_q[wb_addr_q] <= res_q;
          end
          psr_q      <= psr_d;
          wb_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          wb_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign alu_rdest  = opa_q;
  assign alu_rsrc   = opb_q;
  assign alu_opcode = aluop_q;
  assign psr        = psr_q;
  assign wb_valid   = wb_valid_q;
  assign wb_addr    = wb_addr_q;
  assign wb_data    = res_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_ctrl : self-checking bench with a behavioural ALU and an
//                    instruction-level reference model of the sequencer.
// Revision         : 1.0
// ============================================================================
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [3:0]  in_rdest;
  logic [3:0]  in_rsrc;
  logic [7:0]  in_imm;
  logic        in_imm_en;
  logic        in_imm_signed;
  logic [15:0] alu_rdest;
  logic [15:0] alu_rsrc;
  logic [4:0]  alu_opcode;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.NREGS(16), .WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rdest(in_rdest), .in_rsrc(in_rsrc), .in_imm(in_imm),
    .in_imm_en(in_imm_en), .in_imm_signed(in_imm_signed),
    .alu_rdest(alu_rdest), .alu_rsrc(alu_rsrc), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_flags(alu_flags), .psr(psr),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Behavioural ALU: flags {N,Z,F,L,C}; N/L/Z compare a against b for every op.
  function automatic logic [20:0] alu_func(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic n, z, f, l, c;
    s = '0; r = '0; f = 1'b0; c = 1'b0;
    n = $signed(a) < $signed(b);
    l = a < b;
    z = a == b;
    case (op)
      5'd0: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
        f = (a[15] == b[15]) && (r[15] != a[15]);
      end
      5'd1, 5'd2: begin
        r = a - b; c = a < b;
        f = (a[15] != b[15]) && (r[15] != a[15]);
      end
      5'd3: r = a & b;
      5'd4: r = a | b;
      5'd5: r = a ^ b;
      5'd6: r = ~a;
      5'd7: r = a << b[3:0];
      5'd8: r = a >> b[3:0];
      5'd9: r = $unsigned($signed(a) >>> b[3:0]);
      default: r = a ^ b ^ 16'hA5A5;
    endcase
    return {n, z, f, l, c, r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_func(alu_opcode, alu_rdest, alu_rsrc);

  // Reference model state: architectural registers and PSR.
  logic [15:0] exp_regs [16];
  logic [4:0]  exp_psr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_regs[i] = 16'h0;
    exp_psr = 5'h0;
  endtask

  task automatic model_calc(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [7:0] imm, input logic ie, input logic sg,
                            output logic [15:0] a, output logic [15:0] b,
                            output logic [15:0] r, output logic [4:0] fl, output logic wr);
    a = exp_regs[rd];
    b = ie ? {{8{imm[7] & sg}}, imm} : exp_regs[rs];
    {fl, r} = alu_func(op, a, b);
    wr = (op <= 5'd9) && (op != 5'd2);
  endtask

  task automatic model_commit(input logic [4:0] op, input logic [3:0] rd, input logic [15:0] a,
                              input logic [15:0] b, input logic [15:0] r, input logic [4:0] fl,
                              input logic wr);
    if (wr) exp_regs[rd] = r;
    if (op == 5'd0 || op == 5'd1) exp_psr = {fl[4], r == 16'h0, fl[2:0]};
    else if (op == 5'd2)          exp_psr = {fl[4], a == b, fl[2:0]};
  endtask

  task automatic drive(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [7:0] imm, input logic ie, input logic sg);
    in_valid = 1'b1; in_op = op; in_rdest = rd; in_rsrc = rs;
    in_imm = imm; in_imm_en = ie; in_imm_signed = sg;
  endtask

  task automatic check_all_regs(input string nm);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk(nm, dbg_data, exp_regs[i]);
    end
    @(posedge clk); #1;
  endtask

  // One instruction, cycle by cycle; garble keeps in_valid high with junk while busy.
  task automatic do_instr(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs,
                          input logic [7:0] imm, input logic ie, input logic sg, input logic garble);
    logic [15:0] a, b, r;
    logic [4:0]  fl;
    logic        wr;
    int          n;
    model_calc(op, rd, rs, imm, ie, sg, a, b, r, fl, wr);
    n = 0;
    while (in_ready !== 1'b1 && n < 16) begin
      @(posedge clk); #1; n++;
    end
    chk("ready_wait", {31'b0, in_ready}, 32'd1);
    drive(op, rd, rs, imm, ie, sg);
    @(posedge clk); #1;
    if (garble) drive(op ^ 5'd1, rd + 4'd1, rs + 4'd3, ~imm, ~ie, ~sg);
    else        in_valid = 1'b0;
    chk("busy_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("alu_rdest", alu_rdest, a);
    chk("alu_rsrc", alu_rsrc, b);
    chk("alu_opcode", alu_opcode, op);
    chk("wb_early", {31'b0, wb_valid}, 32'd0);
    @(posedge clk); #1;
    chk("wb_valid", {31'b0, wb_valid}, {31'b0, wr});
    if (wr) begin
      chk("wb_addr", wb_addr, rd);
      chk("wb_data", wb_data, r);
    end
    chk("alu_hold", alu_opcode, op);
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_commit(op, rd, a, b, r, fl, wr);
    chk("ready_back", {31'b0, in_ready}, 32'd1);
    chk("wb_drop", {31'b0, wb_valid}, 32'd0);
    chk("psr", psr, exp_psr);
    dbg_addr = rd;
    #1;
    chk("dbg_rd", dbg_data, exp_regs[rd]);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [7:0]  imm;
    logic        ie;
    logic        sg;
    logic        garble;
    logic [15:0] exp_reg;
    logic [4:0]  exp_psr;
  } vec_t;

  vec_t vecs [19];

  initial begin
    logic [15:0] a, b, r, a2, b2, r2;
    logic [4:0]  fl, fl2;
    logic        wr, wr2;

    // Hand-derived expectations: register value of rd afterwards and psr {N,Z,F,L,C}.
    vecs[0]  = '{5'd0, 4'd1, 4'd0, 8'h05, 1'b1, 1'b1, 1'b0, 16'h0005, 5'b10010};
    vecs[1]  = '{5'd0, 4'd2, 4'd0, 8'h80, 1'b1, 1'b1, 1'b0, 16'hFF80, 5'b00010};
    vecs[2]  = '{5'd0, 4'd5, 4'd0, 8'h80, 1'b1, 1'b0, 1'b0, 16'h0080, 5'b10010};
    vecs[3]  = '{5'd0, 4'd3, 4'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 16'hFFFF, 5'b00010};
    vecs[4]  = '{5'd0, 4'd3, 4'd3, 8'h00, 1'b0, 1'b0, 1'b1, 16'hFFFE, 5'b00001};
    vecs[5]  = '{5'd3, 4'd3, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0004, 5'b00001};
    vecs[6]  = '{5'd2, 4'd1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0005, 5'b01000};
    vecs[7]  = '{5'd2, 4'd2, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 16'hFF80, 5'b10000};
    vecs[8]  = '{5'd1, 4'd5, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 16'h007B, 5'b00000};
    vecs[9]  = '{5'd1, 4'd6, 4'd6, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 5'b01000};
    vecs[10] = '{5'd5, 4'd5, 4'd0, 8'hFF, 1'b1, 1'b0, 1'b0, 16'h0084, 5'b01000};
    vecs[11] = '{5'd6, 4'd7, 4'd2, 8'h00, 1'b0, 1'b0, 1'b0, 16'hFFFF, 5'b01000};
    vecs[12] = '{5'd7, 4'd1, 4'd0, 8'h04, 1'b1, 1'b0, 1'b0, 16'h0050, 5'b01000};
    vecs[13] = '{5'd9, 4'd2, 4'd0, 8'h04, 1'b1, 1'b1, 1'b0, 16'hFFF8, 5'b01000};
    vecs[14] = '{5'd8, 4'd3, 4'd0, 8'h01, 1'b1, 1'b0, 1'b0, 16'h0002, 5'b01000};
    vecs[15] = '{5'd4, 4'd3, 4'd5, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0086, 5'b01000};
    vecs[16] = '{5'd12, 4'd3, 4'd5, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0086, 5'b01000};
    vecs[17] = '{5'd1, 4'd1, 4'd0, 8'h01, 1'b1, 1'b1, 1'b0, 16'h004F, 5'b00000};
    vecs[18] = '{5'd0, 4'd7, 4'd0, 8'h01, 1'b1, 1'b1, 1'b0, 16'h0000, 5'b11001};

    reset = 1'b1; in_valid = 1'b0; in_op = '0; in_rdest = '0; in_rsrc = '0;
    in_imm = '0; in_imm_en = 1'b0; in_imm_signed = 1'b0; dbg_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_psr", psr, 0);
    chk("rst_wb", {31'b0, wb_valid}, 32'd0);
    chk("rst_aluop", alu_opcode, 0);
    chk("rst_alua", alu_rdest, 0);
    chk("rst_alub", alu_rsrc, 0);
    check_all_regs("rst_regs");

    for (int i = 0; i < 19; i++) begin
      do_instr(vecs[i].op, vecs[i].rd, vecs[i].rs, vecs[i].imm, vecs[i].ie, vecs[i].sg, vecs[i].garble);
      chk($sformatf("vec%0d_reg", i), dbg_data, vecs[i].exp_reg);
      chk($sformatf("vec%0d_psr", i), psr, vecs[i].exp_psr);
      @(posedge clk); #1;
    end
    check_all_regs("tbl_regs");

    // Second instruction held on in_valid through the first; it must wait for in_ready.
    model_calc(5'd0, 4'd8, 4'd0, 8'h21, 1'b1, 1'b0, a, b, r, fl, wr);
    drive(5'd0, 4'd8, 4'd0, 8'h21, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(5'd1, 4'd8, 4'd0, 8'h01, 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    model_commit(5'd0, 4'd8, a, b, r, fl, wr);
    chk("b2b_ready", {31'b0, in_ready}, 32'd1);
    dbg_addr = 4'd8; #1;
    chk("b2b_first", dbg_data, exp_regs[8]);
    model_calc(5'd1, 4'd8, 4'd0, 8'h01, 1'b1, 1'b0, a2, b2, r2, fl2, wr2);
    @(posedge clk); #1;
    chk("b2b_accept", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("b2b_wb", {31'b0, wb_valid}, 32'd1);
    chk("b2b_data", wb_data, r2);
    @(posedge clk); #1;
    model_commit(5'd1, 4'd8, a2, b2, r2, fl2, wr2);
    #1;
    chk("b2b_second", dbg_data, exp_regs[8]);
    chk("b2b_psr", psr, exp_psr);
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      do_instr(5'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
               8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    check_all_regs("rnd_regs");

    // Reset during EXEC of ADD r4 imm 0x10 aborts it completely.
    drive(5'd0, 4'd4, 4'd0, 8'h10, 1'b1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    chk("abort_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_psr", psr, 0);
    chk("abort_aluop", alu_opcode, 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_nowb", {31'b0, wb_valid}, 32'd0);
      @(posedge clk); #1;
    end
    check_all_regs("abort_regs");
    do_instr(5'd0, 4'd4, 4'd0, 8'h10, 1'b1, 1'b1, 1'b0);
    chk("recover_r4", dbg_data, 16'h0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Multi-cycle execute sequencer sitting directly around the ALU: accepts one decoded instruction at a time, reads operands from an internal 16x16 register file, drives the ALU inputs, captures its result and flags, then writes back and updates the PSR.
- Upstream is the instruction decoder (valid/ready handshake). Downstream is the combinational ALU (alu_* ports).

Parameters:
- NREGS, 16, number of general registers (address width fixed at 4)
- WIDTH, 16, datapath width

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  decoded instruction present
- in_ready  output  1  block can accept an instruction
- in_op  input  5  opcode: ADD=0, SUB=1, CMP=2, AND=3, OR=4, XOR=5, NOT=6, LSH=7, RSH=8, ARSH=9
- in_rdest  input  4  destination/first-operand register
- in_rsrc  input  4  source register
- in_imm  input  8  immediate
- in_imm_en  input  1  use extended immediate instead of reg[rsrc]
- in_imm_signed  input  1  sign-extend immediate (else zero-extend)
- alu_rdest  output  16  ALU Rdest operand
- alu_rsrc  output  16  ALU Rsrc operand
- alu_opcode  output  5  ALU OpCode
- alu_out  input  16  ALU result
- alu_flags  input  5  ALU flags {N,Z,F,L,C} = [4:0]
- psr  output  5  processor status {N,Z,F,L,C}
- wb_valid  output  1  write-back occurring this cycle
- wb_addr  output  4  write-back register
- wb_data  output  16  write-back value
- dbg_addr  input  4  debug read address
- dbg_data  output  16  reg[dbg_addr], combinational

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, reset).
- Reset values: state=IDLE, all registers 0, psr=0, operand regs 0, alu_opcode=0, wb_valid=0, in_ready=1 in the cycle after reset.
- Reset mid-instruction: aborts it. No register write, no PSR update, return to IDLE.
- FSM states are IDLE, READ, EXEC, WB. Each transition occurs on a rising edge.
- IDLE: in_ready=1. On in_valid, latch all in_* fields and go to READ. Otherwise stay in IDLE.
- READ: in_ready=0.
  - Latch opA = reg[rdest].
  - Latch opB = imm_en ? ext(imm) : reg[rsrc].
  - ext: {8{imm[7]&signed}, imm}.
  - Go to EXEC.
- EXEC:
  - alu_rdest=opA, alu_rsrc=opB, alu_opcode=latched op, all driven from registers.
  - Latch alu_out and alu_flags. Go to WB.
- WB: go to IDLE after this cycle.
  - Ops 0,1,3-9: wb_valid=1, wb_addr=rdest, wb_data=latched result; reg[rdest] is written at the end of WB.
  - CMP and undefined ops 10-31: wb_valid=0, no register write.
- PSR update, at the end of WB:
  - ADD, SUB: psr <= latched flags, except Z <= (result==0).
  - CMP: psr <= latched flags, except Z <= (opA==opB).
  - All other ops: psr unchanged.
- Timing:
  - Instruction accepted at edge E0. Write-back visible on dbg_data and psr after E3.
  - in_ready high again in the cycle after E3.
  - Throughput is 1 instruction per 4 cycles. No hazards because execution is serialized.
- in_valid while in_ready=0 is ignored. Fields are not sampled.
- alu_* outputs hold their last values outside EXEC.
- Arithmetic is modulo 2^16. Carry and overflow are reported only via psr.
- dbg_data read is combinational and reflects writes from the previous edge.

Test Plan:
- Reset, then ADD r1 imm=0x05 signed → wb_valid high exactly 3 cycles after accept with wb_addr=1, wb_data=0x0005; dbg r1=0x0005; psr C=0, F=0, Z=0; in_ready returns 1 the following cycle.
- ADD r2 imm=0x80 signed → r2=0xFF80. ADD r5 imm=0x80 unsigned → r5=0x0080.
- ADD r3 imm=0xFF signed (r3=0xFFFF), then ADD r3,r3 → r3=0xFFFE, psr C=1, F=0. Then AND r3,r1 → r3=0x0004 with psr unchanged.
- CMP r1,r1 → wb_valid stays 0 and r1 unchanged, psr Z=1, N=0, L=0. CMP r2(0xFF80),r1(0x0005) → N=1, L=0, Z=0.
- in_valid held high with different fields during READ/EXEC/WB → only the first instruction executes. The second is accepted only when in_ready=1. Opcode 12 → 4 cycles, no write, psr unchanged.
- Assert reset for one cycle while in EXEC of ADD r4 imm=0x10 → r4 stays 0, psr=0, state IDLE, in_ready=1 in the next cycle.
